tetris_parent: RTL and testbench

TETRIS_PARENT -- requirements
Module: tetris_parent

---
 rtl/tetris_parent.sv | 211 +++++++++++++++++++++
 tb/tb_tetris_parent.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_parent.sv
`default_nettype none
// ============================================================================
// Module   : tetris_parent
// Purpose  : Falling-block game core. I/O pieces fall one row per gravity
//            tick from an external slow source; full rows are cleared.
// Revision : 1.0
// ============================================================================
module tetris_parent #(
    parameter int COLS = 8,
    parameter int ROWS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 arduinoClock,
    output logic [ROWS*COLS-1:0] board,
    output logic [15:0]          score,
    output logic                 playing,
    output logic                 game_over
);
    localparam int c_cells = ROWS * COLS;
    localparam int c_rw    = $clog2(ROWS) + 1;
    localparam int c_cw    = $clog2(COLS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_LOCK  = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t             r_state, w_state_nx;
    logic [c_cells-1:0] r_locked, w_locked_nx;
    logic [c_rw-1:0]    r_row, w_row_nx;
    logic [c_cw-1:0]    r_col, w_col_nx;
    logic               r_is_i, w_is_i_nx;
    logic               r_active, w_active_nx;
    logic [15:0]        r_score, w_score_nx;
    logic [7:0]         r_lfsr, w_lfsr_nx;
    logic [c_rw-1:0]    r_scan, w_scan_nx;

    logic               r_sync1, r_sync2, r_sync_d, r_armed;
    logic [1:0]         r_settle;
    logic               w_tick;

    // Cell mask of a piece placed with its top-left cell at (row, col).
    function automatic logic [c_cells-1:0] piece_mask(input logic is_i,
                                                      input logic [c_rw-1:0] row,
                                                      input logic [c_cw-1:0] col);
        logic [c_cells-1:0] m;
        int pr;
        int pc;
        m  = '0;
        pr = int'(row);
        pc = int'(col);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (is_i)
                    m[r*COLS+c] = (r == pr) && (c >= pc) && (c < pc + 4);
                else
                    m[r*COLS+c] = (r >= pr) && (r <= pr + 1) && (c >= pc) && (c <= pc + 1);
            end
        end
        return m;
    endfunction

    // The arm flag waits until the synchronizer holds real input samples, so an
    // input already high at reset release needs a fresh low-to-high transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
            r_armed  <= 1'b0;
            r_settle <= 2'd0;
        end else begin
            r_sync1  <= arduinoClock;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            if (!r_settle[1])
                r_settle <= r_settle + 2'd1;
            else if (!r_sync2)
                r_armed <= 1'b1;
        end
    end

    assign w_tick = r_sync2 & ~r_sync_d & r_armed;

    logic [c_cw-1:0]    w_spawn_col;
    logic [c_cells-1:0] w_spawn_mask, w_cur_mask, w_down_mask, w_shifted;
    logic [c_rw-1:0]    w_bottom;
    logic               w_row_full;

    assign w_spawn_col  = r_lfsr[0] ? c_cw'({r_lfsr[2], 2'b00}) : c_cw'({r_lfsr[2:1], 1'b0});
    assign w_spawn_mask = piece_mask(r_lfsr[0], '0, w_spawn_col);
    assign w_cur_mask   = piece_mask(r_is_i, r_row, r_col);
    assign w_down_mask  = piece_mask(r_is_i, r_row + c_rw'(1), r_col);
    assign w_bottom     = r_row + (r_is_i ? c_rw'(0) : c_rw'(1));

    // Row under scan, and the board with that row removed and everything above dropped.
    always_comb begin
        w_row_full = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            if (c_rw'(i) == r_scan)
                w_row_full = &r_locked[i*COLS +: COLS];
        end
        w_shifted = '0;
        for (int i = 1; i < ROWS; i++) begin
            w_shifted[i*COLS +: COLS] = (c_rw'(i) > r_scan) ? r_locked[i*COLS +: COLS]
                                                            : r_locked[(i-1)*COLS +: COLS];
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_locked_nx = r_locked;
        w_row_nx    = r_row;
        w_col_nx    = r_col;
        w_is_i_nx   = r_is_i;
        w_active_nx = r_active;
        w_score_nx  = r_score;
        w_lfsr_nx   = r_lfsr;
        w_scan_nx   = r_scan;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_locked_nx = '0;
                    w_score_nx  = '0;
                    w_state_nx  = S_SPAWN;
                end
            end
            S_SPAWN: begin
                w_lfsr_nx = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
                w_is_i_nx = r_lfsr[0];
                w_col_nx  = w_spawn_col;
                w_row_nx  = '0;
                if (|(w_spawn_mask & r_locked)) begin
                    w_state_nx = S_OVER;
                end else begin
                    w_active_nx = 1'b1;
                    w_state_nx  = S_FALL;
                end
            end
            S_FALL: begin
                if (w_tick) begin
                    if ((w_bottom < c_rw'(ROWS - 1)) && !(|(w_down_mask & r_locked)))
                        w_row_nx = r_row + c_rw'(1);
                    else
                        w_state_nx = S_LOCK;
                end
            end
            S_LOCK: begin
                w_locked_nx = r_locked | w_cur_mask;
                w_active_nx = 1'b0;
                w_scan_nx   = c_rw'(ROWS - 1);
                w_state_nx  = S_CLEAR;
            end
            S_CLEAR: begin
                // A removed row pulls new content into the same index, so rescan it.
                if (w_row_full) begin
                    w_locked_nx = w_shifted;
                    w_score_nx  = r_score + 16'd1;
                end else if (r_scan == '0) begin
                    w_state_nx = S_SPAWN;
                end else begin
                    w_scan_nx = r_scan - c_rw'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_locked <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_is_i   <= 1'b0;
            r_active <= 1'b0;
            r_score  <= '0;
            r_lfsr   <= 8'hA5;
            r_scan   <= '0;
        end else begin
            r_locked <= w_locked_nx;
            r_row    <= w_row_nx;
            r_col    <= w_col_nx;
            r_is_i   <= w_is_i_nx;
            r_active <= w_active_nx;
            r_score  <= w_score_nx;
            r_lfsr   <= w_lfsr_nx;
            r_scan   <= w_scan_nx;
        end
    end

    assign board     = r_locked | (r_active ? w_cur_mask : '0);
    assign score     = r_score;
    assign playing   = (r_state == S_SPAWN) || (r_state == S_FALL) ||
                       (r_state == S_LOCK)  || (r_state == S_CLEAR);
    assign game_over = (r_state == S_OVER);

endmodule
`default_nettype wire

// File: tb/tb_tetris_parent.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_parent
// Purpose  : Scoreboard bench for tetris_parent with a behavioural game model.
// Revision : 1.0
// ============================================================================
module tb_tetris_parent;
    localparam int COLS = 8;
    localparam int ROWS = 16;
    localparam int N    = ROWS * COLS;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         arduinoClock = 1'b0;
    logic [N-1:0] board;
    logic [15:0]  score;
    logic         playing;
    logic         game_over;

    tetris_parent #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .arduinoClock (arduinoClock),
        .board        (board),
        .score        (score),
        .playing      (playing),
        .game_over    (game_over)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0] board;
        logic [15:0]  score;
        logic         playing;
        logic         game_over;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Game model: 0 idle, 1 playing, 2 over.
    logic [COLS-1:0] m_rows [ROWS];
    logic [7:0]      m_lfsr;
    logic            m_is_i;
    logic            m_active;
    int              m_row, m_col, m_state;
    logic [15:0]     m_score;

    function automatic int cell_r(int row, int k);
        return row + (m_is_i ? 0 : k / 2);
    endfunction

    function automatic int cell_c(int k);
        return m_col + (m_is_i ? k : k % 2);
    endfunction

    function automatic bit fits(int row);
        for (int k = 0; k < 4; k++) begin
            if (cell_r(row, k) >= ROWS) return 1'b0;
            if (m_rows[cell_r(row, k)][cell_c(k)]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.board = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                e.board[r*COLS+c] = m_rows[r][c];
        if (m_active)
            for (int k = 0; k < 4; k++)
                e.board[cell_r(m_row, k)*COLS + cell_c(k)] = 1'b1;
        e.score     = m_score;
        e.playing   = (m_state == 1);
        e.game_over = (m_state == 2);
        return e;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
        m_lfsr = 8'hA5; m_score = '0; m_active = 1'b0; m_state = 0;
        m_row = 0; m_col = 0; m_is_i = 1'b0;
    endtask

    task automatic m_spawn();
        m_is_i = m_lfsr[0];
        m_col  = m_lfsr[0] ? 4 * m_lfsr[2] : 2 * m_lfsr[2:1];
        m_row  = 0;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (fits(0)) begin
            m_active = 1'b1; m_state = 1;
        end else begin
            m_active = 1'b0; m_state = 2;
        end
    endtask

    task automatic m_start();
        if (m_state != 1) begin
            for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
            m_score = '0;
            m_spawn();
        end
    endtask

    // Applies one gravity tick to the model; lw reports a lock (long settle).
    task automatic m_tick(output bit lw);
        logic [COLS-1:0] tmp [ROWS];
        int dst;
        lw = 1'b0;
        if (m_state != 1) return;
        if (fits(m_row + 1)) begin
            m_row++;
        end else begin
            lw = 1'b1;
            for (int k = 0; k < 4; k++) m_rows[cell_r(m_row, k)][cell_c(k)] = 1'b1;
            m_active = 1'b0;
            dst = ROWS - 1;
            for (int r = ROWS - 1; r >= 0; r--) begin
                if (m_rows[r] != '1) begin
                    tmp[dst] = m_rows[r];
                    dst--;
                end else begin
                    m_score++;
                end
            end
            while (dst >= 0) begin
                tmp[dst] = '0;
                dst--;
            end
            m_rows = tmp;
            m_spawn();
        end
    endtask

    task automatic clk(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_tick(bit lw);
        arduinoClock = 1'b1; clk(3);
        arduinoClock = 1'b0; clk(3);
        if (lw) clk(40);
    endtask

    task automatic pulse();
        bit lw;
        m_tick(lw);
        sb.push_back(snap());
        drive_tick(lw);
    endtask

    task automatic do_start();
        m_start();
        sb.push_back(snap());
        start = 1'b1; clk(1);
        start = 1'b0; clk(3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        clk(2);
        reset = 1'b0;
        clk(1);
    endtask

    task automatic test_reset();
        exp_t e, got;
        arduinoClock = 1'b0;
        do_reset();
        sb.push_back(snap());
        got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                     got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
        end
        for (int i = 0; i < 10; i++) begin
            pulse();
            got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL idle_tick: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                         got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
            end
        end
        clk(40);
    endtask

    task automatic test_start();
        exp_t e, got;
        do_start();
        got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL start_spawn: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                     got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
        end
        vectors++;
        if (board !== N'(128'hF0) || playing !== 1'b1) begin
            miscompares++;
            $display("FAIL first_piece: got board=%h playing=%b, want board=%h playing=1", board, playing, N'(128'hF0));
        end
    endtask

    task automatic test_fall();
        exp_t e, got;
        logic [N-1:0] want;
        for (int i = 1; i <= 16; i++) begin
            pulse();
            got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL fall_%0d: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                         i, got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
            end
            if (i == 15) begin
                want = '0; want[15*COLS +: COLS] = 8'hF0; vectors++;
                if (board !== want) begin
                    miscompares++;
                    $display("FAIL row15: got board=%h, want board=%h", board, want);
                end
            end
        end
        want = '0; want[15*COLS +: COLS] = 8'hF0; want[15:0] = 16'h0C0C; vectors++;
        if (board !== want) begin
            miscompares++;
            $display("FAIL lock_then_o: got board=%h, want board=%h", board, want);
        end
    endtask

    task automatic test_held();
        exp_t e, got;
        bit lw;
        m_tick(lw);
        sb.push_back(snap());
        arduinoClock = 1'b1; clk(1000);
        got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL held_high: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                     got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
        end
        arduinoClock = 1'b0; clk(4);
    endtask

    task automatic test_ard_high_reset();
        exp_t e, got;
        arduinoClock = 1'b1;
        do_reset();
        do_start();
        clk(30);
        got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL high_at_reset: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                     got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
        end
        arduinoClock = 1'b0; clk(4);
        pulse();
        got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL rearm: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                     got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
        end
    endtask

    task automatic test_play();
        exp_t e, got;
        int guard = 0;
        while (m_state != 2 && guard < 5000) begin
            pulse();
            guard++;
            got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL play_tick_%0d: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                         guard, got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
            end
        end
        vectors++;
        if (m_state != 2 || m_score == 0) begin
            miscompares++;
            $display("FAIL play_coverage: got over=%b score=%0d after %0d ticks, want over=1 and score>0", game_over, score, guard);
        end
        for (int i = 0; i < 5; i++) begin
            pulse();
            got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL over_frozen: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                         got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
            end
        end
        do_start();
        got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL restart: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                     got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
        end
    endtask

    task automatic test_async_reset();
        exp_t e, got;
        bit lw;
        bit done = 1'b0;
        pulse(); void'(sb.pop_front());
        @(posedge clock); #3;
        reset = 1'b1; m_reset(); sb.push_back(snap()); #1;
        got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_fall: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                     got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
        end
        @(posedge clock); #1; reset = 1'b0; clk(2);
        do_start(); void'(sb.pop_front());
        for (int i = 0; i < 40 && !done; i++) begin
            m_tick(lw);
            if (!lw) begin
                drive_tick(1'b0);
            end else begin
                arduinoClock = 1'b1; clk(3);
                arduinoClock = 1'b0; clk(3);
                #2; reset = 1'b1; m_reset(); sb.push_back(snap()); #1;
                got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL reset_clear: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                             got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
                end
                done = 1'b1;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL reach_clear: got no lock within 40 ticks, want a lock");
        end
        @(posedge clock); #1; reset = 1'b0; clk(3);
        sb.push_back(snap());
        got = {board, score, playing, game_over}; e = sb.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL post_reset: got board=%h score=%0d playing=%b over=%b, want board=%h score=%0d playing=%b over=%b",
                     got.board, got.score, got.playing, got.game_over, e.board, e.score, e.playing, e.game_over);
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_start();
        test_fall();
        test_held();
        test_ard_high_reset();
        test_play();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no completion by time limit, want summary");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
